// File: rtl/proj_pkg.sv
// ============================================================================
// Module  : proj_pkg
// Brief   : Shared types and constants for the MinHash sketcher slice.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package proj_pkg;

  localparam int unsigned c_DEF_SIG_LEN    = 32;
  localparam int unsigned c_DEF_INDICE_LEN = 10;

  localparam logic [31:0] c_DEFAULT_SEED = 32'hac718add;
  localparam logic [31:0] c_MIX_M1       = 32'h85ebca6b;
  localparam logic [31:0] c_MIX_M2       = 32'hc2b2ae35;

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_EMIT  = 2'd3;

  typedef enum logic [1:0] {
    SK_FILL  = 2'd0,
    SK_RUN   = 2'd1,
    SK_DRAIN = 2'd2,
    SK_EMIT  = 2'd3
  } sketch_state_e;

  typedef struct packed {
    logic [c_DEF_SIG_LEN-1:0]    sig;
    logic [c_DEF_INDICE_LEN-1:0] idx;
    logic                        vld;
  } minhash_entry_t;

endpackage

`default_nettype wire

// File: rtl/proj_mix_hash.sv
// ============================================================================
// Module  : proj_mix_hash
// Brief   : Registered k-mer fold (XOR of SIG_LEN chunks) plus murmur-style mix.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module proj_mix_hash
  import proj_pkg::*;
#(
  parameter int          KMER_BITS = 32,
  parameter int          SIG_LEN   = 32,
  parameter logic [31:0] SEED      = c_DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [KMER_BITS-1:0] in_kmer,
  output logic                 out_vld,
  output logic [SIG_LEN-1:0]   out_sig
);

  localparam int                 c_NCH  = (KMER_BITS + SIG_LEN - 1) / SIG_LEN;
  localparam logic [SIG_LEN-1:0] c_SEED = SIG_LEN'(SEED);
  localparam logic [SIG_LEN-1:0] c_M1   = SIG_LEN'(c_MIX_M1);
  localparam logic [SIG_LEN-1:0] c_M2   = SIG_LEN'(c_MIX_M2);

  logic [c_NCH*SIG_LEN-1:0] w_pad;
  logic [SIG_LEN-1:0]       w_fold;
  logic [SIG_LEN-1:0]       w_h;
  logic                     vld_q;
  logic [SIG_LEN-1:0]       sig_q;

  always_comb begin
    w_pad                = '0;
    w_pad[KMER_BITS-1:0] = in_kmer;
    w_fold               = '0;
    for (int c = 0; c < c_NCH; c++) begin
      w_fold = w_fold ^ w_pad[c*SIG_LEN +: SIG_LEN];
    end
    w_h = w_fold ^ c_SEED;
    w_h = w_h ^ (w_h >> 16);
    w_h = w_h * c_M1;
    w_h = w_h ^ (w_h >> 13);
    w_h = w_h * c_M2;
    w_h = w_h ^ (w_h >> 16);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      sig_q <= '0;
    end else begin
      vld_q <= in_vld;
      if (in_vld) begin
        sig_q <= w_h;
      end
    end
  end

  assign out_vld = vld_q;
  assign out_sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/proj_minhash_sketcher.sv
// ============================================================================
// Module  : proj_minhash_sketcher
// Brief   : Streaming bottom-S MinHash sketcher with valid/ready in and out.
//           Define MINHASH_DEDUP_EN to keep only distinct signatures.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module proj_minhash_sketcher
  import proj_pkg::*;
#(
  parameter int          BASE_LEN    = 2,
  parameter int          KMER_LEN    = 16,
  parameter int          SKETCH_SIZE = 8,
  parameter int          INDICE_LEN  = 10,
  parameter int          SIG_LEN     = 32,
  parameter logic [31:0] SEED        = c_DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BASE_LEN-1:0]   in_base,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDICE_LEN-1:0] out_index,
  output logic [SIG_LEN-1:0]    out_sig,
  output logic                  out_last,
  output logic                  out_empty,
  output logic                  overflow
);

  localparam int                    c_KMER_BITS = BASE_LEN * KMER_LEN;
  localparam int                    c_PTR_W     = (SKETCH_SIZE > 1) ? $clog2(SKETCH_SIZE) : 1;
  localparam int                    c_CNT_W     = $clog2(KMER_LEN);
  localparam logic [INDICE_LEN-1:0] c_IDX_MAX   = '1;

  logic [1:0]             state_q, state_d;
  logic [c_KMER_BITS-1:0] kmer_q, kmer_d;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic [INDICE_LEN-1:0]  idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic                   drain_q, drain_d;
  logic [c_PTR_W-1:0]     ptr_q, ptr_d;
  logic [INDICE_LEN-1:0]  hidx_q;

  logic [SIG_LEN-1:0]     ent_sig_q [SKETCH_SIZE];
  logic [INDICE_LEN-1:0]  ent_idx_q [SKETCH_SIZE];
  logic                   ent_vld_q [SKETCH_SIZE];

  logic                   w_accept;
  logic [c_KMER_BITS-1:0] w_kmer_shift;
  logic                   w_kmer_done;
  logic                   w_hvld;
  logic [SIG_LEN-1:0]     w_hsig;
  logic                   w_ins;
  logic [SKETCH_SIZE-1:0] w_gt;
  logic                   w_emit;
  logic                   w_empty;
  logic                   w_last;
  logic                   w_next_vld;
  logic                   w_clear;
  logic [SIG_LEN-1:0]     w_sel_sig;
  logic [INDICE_LEN-1:0]  w_sel_idx;
  logic [SIG_LEN-1:0]     w_src_sig [SKETCH_SIZE];
  logic [INDICE_LEN-1:0]  w_src_idx [SKETCH_SIZE];
  logic                   w_src_vld [SKETCH_SIZE];

  assign in_ready     = !rst && ((state_q == c_ST_FILL) || (state_q == c_ST_RUN));
  assign w_accept     = in_valid && in_ready;
  assign w_kmer_shift = {kmer_q[c_KMER_BITS-BASE_LEN-1:0], in_base};
  assign w_kmer_done  = w_accept && (state_q == c_ST_RUN);
  assign w_emit       = (state_q == c_ST_EMIT);
  assign w_empty      = !ent_vld_q[0];
  assign w_last       = w_empty || !w_next_vld;
  assign w_clear      = w_emit && out_ready && w_last;

  proj_mix_hash #(
    .KMER_BITS (c_KMER_BITS),
    .SIG_LEN   (SIG_LEN),
    .SEED      (SEED)
  ) u_hash (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (w_kmer_done),
    .in_kmer (w_kmer_shift),
    .out_vld (w_hvld),
    .out_sig (w_hsig)
  );

  always_ff @(posedge clk) begin
    if (w_kmer_done) begin
      hidx_q <= idx_q;
    end
  end

  // Slots are sorted with valid entries packed low, so w_gt is thermometer
  // shaped: the first set bit is the insertion point, ties land after equals.
  always_comb begin
    for (int i = 0; i < SKETCH_SIZE; i++) begin
      w_gt[i] = !ent_vld_q[i] || (ent_sig_q[i] > w_hsig);
    end
  end

`ifdef MINHASH_DEDUP_EN
  logic w_dup;
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < SKETCH_SIZE; i++) begin
      if (ent_vld_q[i] && (ent_sig_q[i] == w_hsig)) begin
        w_dup = 1'b1;
      end
    end
  end
  assign w_ins = w_hvld && !w_dup;
`else
  assign w_ins = w_hvld;
`endif

  for (genvar g = 0; g < SKETCH_SIZE; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign w_src_sig[g] = w_hsig;
      assign w_src_idx[g] = hidx_q;
      assign w_src_vld[g] = 1'b1;
    end else begin : g_tail
      assign w_src_sig[g] = w_gt[g-1] ? ent_sig_q[g-1] : w_hsig;
      assign w_src_idx[g] = w_gt[g-1] ? ent_idx_q[g-1] : hidx_q;
      assign w_src_vld[g] = w_gt[g-1] ? ent_vld_q[g-1] : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SKETCH_SIZE; i++) begin
      if (rst || w_clear) begin
        ent_vld_q[i] <= 1'b0;
      end else if (w_ins && w_gt[i]) begin
        ent_vld_q[i] <= w_src_vld[i];
        ent_sig_q[i] <= w_src_sig[i];
        ent_idx_q[i] <= w_src_idx[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kmer_d  = kmer_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    drain_d = drain_q;
    ptr_d   = ptr_q;
    if (w_accept) begin
      kmer_d = w_kmer_shift;
    end
    case (state_q)
      c_ST_FILL: begin
        if (w_accept) begin
          cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            state_d = c_ST_DRAIN;
          end else if (cnt_q == c_CNT_W'(KMER_LEN - 2)) begin
            state_d = c_ST_RUN;
          end
        end
      end
      c_ST_RUN: begin
        if (w_accept) begin
          if (idx_q == c_IDX_MAX) begin
            ovf_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (in_last) begin
            state_d = c_ST_DRAIN;
          end
        end
      end
      c_ST_DRAIN: begin
        drain_d = !drain_q;
        if (drain_q) begin
          state_d = c_ST_EMIT;
        end
      end
      default: begin
        if (out_ready) begin
          if (w_last) begin
            state_d = c_ST_FILL;
            cnt_d   = '0;
            idx_d   = '0;
            ovf_d   = 1'b0;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_FILL;
      kmer_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      drain_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      kmer_q  <= kmer_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      drain_q <= drain_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    w_sel_sig  = '0;
    w_sel_idx  = '0;
    w_next_vld = 1'b0;
    for (int i = 0; i < SKETCH_SIZE; i++) begin
      if (ptr_q == c_PTR_W'(i)) begin
        w_sel_sig = ent_sig_q[i];
        w_sel_idx = ent_idx_q[i];
      end
    end
    for (int i = 0; i < SKETCH_SIZE - 1; i++) begin
      if (ptr_q == c_PTR_W'(i)) begin
        w_next_vld = ent_vld_q[i+1];
      end
    end
  end

  always_comb begin
    out_valid = w_emit;
    out_sig   = '0;
    out_index = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    if (w_emit) begin
      out_last  = w_last;
      out_empty = w_empty;
      if (!w_empty) begin
        out_sig   = w_sel_sig;
        out_index = w_sel_idx;
      end
    end
  end

  assign overflow = ovf_q;

endmodule

`default_nettype wire
